// File: rtl/m20k_sdp_port_arbiter_pkg.sv
// ============================================================================
// Module   : m20k_sdp_port_arbiter_pkg
// Purpose  : Shared FSM encoding and sizing helper for the M20K SDP arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package m20k_sdp_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m20k_sdp_port_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : m20k_sdp_port_arbiter_rr_arbiter
// Purpose  : Combinational round-robin picker; first request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m20k_sdp_port_arbiter_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            // Modulo keeps the scan correct for non-power-of-two N.
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/m20k_sdp_port_arbiter.sv
// ============================================================================
// Module   : m20k_sdp_port_arbiter
// Purpose  : Clears an external SDP M20K after reset, then round-robin shares
//            its write and read ports with write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m20k_sdp_port_arbiter
    import m20k_sdp_port_arbiter_pkg::*;
#(
    parameter  int ABITS = 10,
    parameter  int DBITS = 20,
    parameter  int NREQ  = 2,
    localparam int IDW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic                    CLK1,
    input  logic                    ARSTN,
    input  logic [NREQ-1:0]         wr_req,
    input  logic [NREQ*ABITS-1:0]   wr_addr,
    input  logic [NREQ*DBITS-1:0]   wr_data,
    output logic [NREQ-1:0]         wr_gnt,
    input  logic [NREQ-1:0]         rd_req,
    input  logic [NREQ*ABITS-1:0]   rd_addr,
    output logic [NREQ-1:0]         rd_gnt,
    output logic                    rd_valid,
    output logic [IDW-1:0]          rd_id,
    output logic [DBITS-1:0]        rd_data,
    output logic                    busy,
    output logic [ABITS-1:0]        ram_waddr,
    output logic [DBITS-1:0]        ram_wdata,
    output logic                    ram_wen,
    output logic [ABITS-1:0]        ram_raddr,
    input  logic [DBITS-1:0]        ram_rdata
);

    state_e             state_q, state_d;
    logic [ABITS-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [IDW-1:0]     rd_ptr_q, rd_ptr_d;
    logic               rd_valid_q, rd_valid_d;
    logic [IDW-1:0]     rd_id_q, rd_id_d;
    logic               fwd_q, fwd_d;
    logic [DBITS-1:0]   fwd_data_q, fwd_data_d;
    logic [DBITS-1:0]   last_q, last_d;

    logic               run;
    logic [NREQ-1:0]    wr_req_g, rd_req_g;
    logic [IDW-1:0]     wr_idx, rd_idx;
    logic               wr_any, rd_any;
    logic [ABITS-1:0]   sel_waddr, sel_raddr;
    logic [DBITS-1:0]   sel_wdata;

    assign run      = (state_q == ST_RUN);
    assign busy     = ~run;
    assign wr_req_g = wr_req & {NREQ{run}};
    assign rd_req_g = rd_req & {NREQ{run}};

    m20k_sdp_port_arbiter_rr_arbiter #(.N(NREQ), .IW(IDW)) u_wr_arb (
        .req_i (wr_req_g),
        .ptr_i (wr_ptr_q),
        .gnt_o (wr_gnt),
        .idx_o (wr_idx),
        .any_o (wr_any)
    );

    m20k_sdp_port_arbiter_rr_arbiter #(.N(NREQ), .IW(IDW)) u_rd_arb (
        .req_i (rd_req_g),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_gnt),
        .idx_o (rd_idx),
        .any_o (rd_any)
    );

    assign sel_waddr = wr_addr[wr_idx*ABITS +: ABITS];
    assign sel_wdata = wr_data[wr_idx*DBITS +: DBITS];
    assign sel_raddr = rd_addr[rd_idx*ABITS +: ABITS];

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] idx);
        return (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = 1'b0;
        rd_id_d    = rd_id_q;
        fwd_d      = 1'b0;
        fwd_data_d = fwd_data_q;
        ram_wen    = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        ram_raddr  = '0;

        if (state_q == ST_CLEAR) begin
            ram_wen   = 1'b1;
            ram_waddr = cnt_q;
            // Terminal compare instead of a wider counter; it parks at max.
            if (cnt_q == {ABITS{1'b1}}) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (wr_any) begin
                ram_wen   = 1'b1;
                ram_waddr = sel_waddr;
                ram_wdata = sel_wdata;
                wr_ptr_d  = next_ptr(wr_idx);
            end
            if (rd_any) begin
                ram_raddr  = sel_raddr;
                rd_ptr_d   = next_ptr(rd_idx);
                rd_valid_d = 1'b1;
                rd_id_d    = rd_idx;
            end
            // The RAM returns old data on a same-address collision.
            if (wr_any && rd_any && (sel_waddr == sel_raddr)) begin
                fwd_d      = 1'b1;
                fwd_data_d = sel_wdata;
            end
        end
    end

    always_comb begin
        if (!rd_valid_q) begin
            rd_data = last_q;
        end else if (fwd_q) begin
            rd_data = fwd_data_q;
        end else begin
            rd_data = ram_rdata;
        end
        last_d = rd_data;
    end

    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;

    always_ff @(posedge CLK1 or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            if (rd_valid_q) begin
                last_q <= last_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m20k_sdp_port_arbiter.sv
// ============================================================================
// Module   : tb_m20k_sdp_port_arbiter
// Purpose  : Directed self-checking bench with a behavioural 1-cycle SDP RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m20k_sdp_port_arbiter;

    localparam int ABITS = 4;
    localparam int DBITS = 20;
    localparam int NREQ  = 3;

    logic                  CLK1;
    logic                  ARSTN;
    logic [NREQ-1:0]       wr_req;
    logic [NREQ*ABITS-1:0] wr_addr;
    logic [NREQ*DBITS-1:0] wr_data;
    logic [NREQ-1:0]       wr_gnt;
    logic [NREQ-1:0]       rd_req;
    logic [NREQ*ABITS-1:0] rd_addr;
    logic [NREQ-1:0]       rd_gnt;
    logic                  rd_valid;
    logic [1:0]            rd_id;
    logic [DBITS-1:0]      rd_data;
    logic                  busy;
    logic [ABITS-1:0]      ram_waddr;
    logic [DBITS-1:0]      ram_wdata;
    logic                  ram_wen;
    logic [ABITS-1:0]      ram_raddr;
    logic [DBITS-1:0]      ram_rdata;

    logic [DBITS-1:0]      mem [2**ABITS];

    int checks = 0;
    int errors = 0;

    m20k_sdp_port_arbiter #(.ABITS(ABITS), .DBITS(DBITS), .NREQ(NREQ)) dut (
        .CLK1      (CLK1),
        .ARSTN     (ARSTN),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    // Old-data read-during-write, like the M20K in this mode.
    always @(posedge CLK1) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic test_reset();
        ARSTN = 1'b0; wr_req = '0; rd_req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b expected 1", busy); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", rd_valid); end
        checks++; if (rd_id !== 2'd0) begin errors++; $display("FAIL reset_rd_id: got %0d expected 0", rd_id); end
        checks++; if (ram_wen !== 1'b1 || ram_waddr !== 4'd0 || ram_wdata !== 20'd0) begin
            errors++; $display("FAIL reset_ram: got wen=%0b waddr=%0d wdata=%0h expected 1/0/0", ram_wen, ram_waddr, ram_wdata); end
    endtask

    task automatic test_clear();
        int bad;
        bad = 0;
        wr_req = '1; rd_req = '1;
        ARSTN = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (busy !== 1'b1 || ram_wen !== 1'b1 || ram_waddr !== 4'(c) || ram_wdata !== 20'd0 ||
                wr_gnt !== 3'b000 || rd_gnt !== 3'b000 || ram_raddr !== 4'd0) begin
                bad++;
                $display("FAIL clear_cycle%0d: got busy=%0b wen=%0b waddr=%0d wdata=%0h wg=%b rg=%b expected 1/1/%0d/0/000/000",
                         c, busy, ram_wen, ram_waddr, ram_wdata, wr_gnt, rd_gnt, c);
            end
            tick();
        end
        checks++; if (bad != 0) errors++;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_done_busy: got %0b expected 0", busy); end
        wr_req = '0; rd_req = '0;
        #1;
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL idle_wen: got %0b expected 0", ram_wen); end
    endtask

    task automatic test_write_fairness();
        int e;
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*ABITS +: ABITS] = 4'(i + 1);
            wr_data[i*DBITS +: DBITS] = 20'h00100 + 20'(i);
        end
        wr_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            e = k % 3;
            #1;
            checks++;
            if (wr_gnt !== 3'(1 << e) || ram_wen !== 1'b1 || ram_waddr !== 4'(e + 1) ||
                ram_wdata !== (20'h00100 + 20'(e))) begin
                errors++;
                $display("FAIL write_fair_%0d: got gnt=%b waddr=%0d wdata=%0h expected gnt=%b waddr=%0d wdata=%0h",
                         k, wr_gnt, ram_waddr, ram_wdata, 3'(1 << e), e + 1, 20'h00100 + 20'(e));
            end
            tick();
        end
        wr_req = '0;
    endtask

    task automatic test_read_return();
        wr_req = 3'b010; wr_addr[1*ABITS +: ABITS] = 4'd5; wr_data[1*DBITS +: DBITS] = 20'h0ABCD;
        #1;
        checks++; if (wr_gnt !== 3'b010) begin errors++; $display("FAIL rr_wr_gnt: got %b expected 010", wr_gnt); end
        tick();
        wr_req = '0;
        rd_req = 3'b010; rd_addr[1*ABITS +: ABITS] = 4'd5;
        #1;
        checks++; if (rd_gnt !== 3'b010 || ram_raddr !== 4'd5) begin
            errors++; $display("FAIL rr_rd_gnt: got gnt=%b raddr=%0d expected 010/5", rd_gnt, ram_raddr); end
        tick();
        rd_req = '0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_id !== 2'd1 || rd_data !== 20'h0ABCD) begin
            errors++; $display("FAIL rr_return: got v=%0b id=%0d data=%0h expected 1/1/0abcd", rd_valid, rd_id, rd_data); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 20'h0ABCD) begin
            errors++; $display("FAIL rr_no_read: got v=%0b data=%0h expected 0/0abcd(held)", rd_valid, rd_data); end
    endtask

    task automatic test_collision();
        wr_req = 3'b001; wr_addr[0 +: ABITS] = 4'd7; wr_data[0 +: DBITS] = 20'h12345;
        rd_req = 3'b001; rd_addr[0 +: ABITS] = 4'd7;
        #1;
        checks++; if (wr_gnt !== 3'b001 || rd_gnt !== 3'b001) begin
            errors++; $display("FAIL col_gnts: got wg=%b rg=%b expected 001/001", wr_gnt, rd_gnt); end
        tick();
        wr_addr[0 +: ABITS] = 4'd8; wr_data[0 +: DBITS] = 20'h55555;
        rd_addr[0 +: ABITS] = 4'd1;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_id !== 2'd0 || rd_data !== 20'h12345) begin
            errors++; $display("FAIL col_forward: got v=%0b id=%0d data=%0h expected 1/0/12345", rd_valid, rd_id, rd_data); end
        tick();
        wr_req = '0;
        rd_addr[0 +: ABITS] = 4'd7;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 20'h00100) begin
            errors++; $display("FAIL col_diff_addr: got v=%0b data=%0h expected 1/00100", rd_valid, rd_data); end
        tick();
        rd_req = '0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 20'h12345) begin
            errors++; $display("FAIL col_readback: got v=%0b data=%0h expected 1/12345", rd_valid, rd_data); end
    endtask

    task automatic test_sparse();
        rd_addr[2*ABITS +: ABITS] = 4'd2;
        rd_addr[0*ABITS +: ABITS] = 4'd3;
        rd_addr[1*ABITS +: ABITS] = 4'd5;
        rd_req = 3'b100;
        #1;
        checks++; if (rd_gnt !== 3'b100) begin errors++; $display("FAIL sparse_g2: got %b expected 100", rd_gnt); end
        tick();
        rd_req = '0;
        #1;
        checks++; if (rd_valid !== 1'b1 || rd_id !== 2'd2 || rd_data !== 20'h00101) begin
            errors++; $display("FAIL sparse_d2: got v=%0b id=%0d data=%0h expected 1/2/00101", rd_valid, rd_id, rd_data); end
        tick(); tick();
        rd_req = 3'b001;
        #1;
        checks++; if (rd_gnt !== 3'b001) begin errors++; $display("FAIL sparse_g0: got %b expected 001", rd_gnt); end
        tick();
        rd_req = '0;
        #1;
        checks++; if (rd_id !== 2'd0 || rd_data !== 20'h00102) begin
            errors++; $display("FAIL sparse_d0: got id=%0d data=%0h expected 0/00102", rd_id, rd_data); end
        tick();
        rd_req = 3'b111;
        #1;
        checks++; if (rd_gnt !== 3'b010) begin errors++; $display("FAIL sparse_ptr_held: got %b expected 010", rd_gnt); end
        tick();
        rd_req = '0;
        #1;
        checks++; if (rd_id !== 2'd1 || rd_data !== 20'h0ABCD) begin
            errors++; $display("FAIL sparse_d1: got id=%0d data=%0h expected 1/0abcd", rd_id, rd_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        rd_req = 3'b010;
        #1;
        checks++; if (rd_gnt !== 3'b010) begin errors++; $display("FAIL rm_gnt: got %b expected 010", rd_gnt); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rm_valid_pre: got %0b expected 1", rd_valid); end
        ARSTN = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b1 || rd_gnt !== 3'b000 || ram_waddr !== 4'd0) begin
            errors++; $display("FAIL rm_async: got v=%0b busy=%0b rg=%b waddr=%0d expected 0/1/000/0",
                               rd_valid, busy, rd_gnt, ram_waddr); end
        rd_req = '0;
        tick();
        ARSTN = 1'b1;
        #1;
        checks++; if (ram_waddr !== 4'd0 || ram_wen !== 1'b1) begin
            errors++; $display("FAIL rm_restart0: got waddr=%0d wen=%0b expected 0/1", ram_waddr, ram_wen); end
        tick();
        checks++; if (ram_waddr !== 4'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL rm_restart1: got waddr=%0d busy=%0b expected 1/1", ram_waddr, busy); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_fairness();
        test_read_return();
        test_collision();
        test_sparse();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
